// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed seven-segment driver. Scans NUM_DIGITS digits over a
//   shared segment bus. Each digit slot is SCAN_DIV cycles long: one blank
//   anti-ghost cycle, then the digit is enabled. Inputs are shadowed once per
//   frame so a frame never mixes old and new values. Per-digit flash masking
//   and PWM brightness gating are applied to the segments only; the digit
//   enable stays asserted.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   on          1 = show digits, 0 = show mode glyph on digit 0
//   mode        mode glyph select
//   digits      nibble i at [4i+3:4i], digit 0 rightmost
//   flash_mask  bit i blinks digit i
//   bright      PWM duty, 0 = dark, all-ones = always lit
//   seg         {a,b,c,d,e,f,g}, active-high, registered
//   an          one-hot digit enable, active-high, registered
//   frame_tick  one-cycle pulse on the first blank cycle of each frame
module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 2000,
  parameter int unsigned BLINK_FRAMES = 50,
  parameter int unsigned PWM_BITS     = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    on,
  input  logic [2:0]              mode,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   flash_mask,
  input  logic [PWM_BITS-1:0]     bright,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int unsigned PRE_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLINK_FRAMES - 1);

  function automatic logic [6:0] digit_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'd0:    g = 7'b1111110;
      4'd1:    g = 7'b0110000;
      4'd2:    g = 7'b1101101;
      4'd3:    g = 7'b1111001;
      4'd4:    g = 7'b0110011;
      4'd5:    g = 7'b1011011;
      4'd6:    g = 7'b1011111;
      4'd7:    g = 7'b1110000;
      4'd8:    g = 7'b1111111;
      4'd9:    g = 7'b1111011;
      4'd10:   g = 7'b1110111;
      4'd11:   g = 7'b1100111;
      4'd12:   g = 7'b0000001;
      default: g = 7'b0000000;
    endcase
    return g;
  endfunction

  function automatic logic [6:0] mode_glyph(input logic [2:0] m);
    logic [6:0] g;
    case (m)
      3'd0:    g = 7'b0001110;
      3'd1:    g = 7'b1111110;
      3'd2:    g = 7'b1001110;
      3'd3:    g = 7'b0101111;
      3'd4:    g = 7'b1001111;
      3'd5:    g = 7'b0111101;
      default: g = 7'b0000000;
    endcase
    return g;
  endfunction

  logic [PRE_W-1:0]        pre_q, pre_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [FCNT_W-1:0]       fcnt_q, fcnt_d;
  logic                    blink_q, blink_d;
  logic [PWM_BITS-1:0]     pwm_q, pwm_d;
  logic                    on_sh_q, on_sh_d;
  logic [2:0]              mode_sh_q, mode_sh_d;
  logic [4*NUM_DIGITS-1:0] digits_sh_q, digits_sh_d;
  logic [NUM_DIGITS-1:0]   flash_sh_q, flash_sh_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_tick_q, frame_tick_d;

  logic                    eof;
  logic [3:0]              nib;
  logic                    flash_bit;
  logic [NUM_DIGITS-1:0]   an_sel;
  logic [6:0]              glyph;
  logic                    lit;

  // Scan counters, blink phase, PWM and frame-synchronous input shadows.
  always_comb begin
    pre_d       = pre_q + 1'b1;
    idx_d       = idx_q;
    fcnt_d      = fcnt_q;
    blink_d     = blink_q;
    pwm_d       = pwm_q + 1'b1;
    on_sh_d     = on_sh_q;
    mode_sh_d   = mode_sh_q;
    digits_sh_d = digits_sh_q;
    flash_sh_d  = flash_sh_q;

    eof = (pre_q == PRE_LAST) && (idx_q == IDX_LAST);

    if (pre_q == PRE_LAST) begin
      pre_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    if (eof) begin
      on_sh_d     = on;
      mode_sh_d   = mode;
      digits_sh_d = digits;
      flash_sh_d  = flash_mask;
      if (fcnt_q == FCNT_LAST) begin
        fcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  // Output decode from the current slot; registered so an lags idx by one.
  always_comb begin
    nib       = '0;
    flash_bit = 1'b0;
    an_sel    = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib       = digits_sh_q[4*i +: 4];
        flash_bit = flash_sh_q[i];
        an_sel[i] = 1'b1;
      end
    end

    if (on_sh_q)
      glyph = digit_glyph(nib);
    else if (idx_q == '0)
      glyph = mode_glyph(mode_sh_q);
    else
      glyph = '0;

    lit = (bright == '1) || (pwm_q < bright);

    seg_d        = '0;
    an_d         = '0;
    frame_tick_d = (pre_q == '0) && (idx_q == '0);
    if (pre_q != '0) begin
      an_d  = an_sel;
      seg_d = ((blink_q && flash_bit) || !lit) ? '0 : glyph;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q        <= '0;
      idx_q        <= '0;
      fcnt_q       <= '0;
      blink_q      <= 1'b0;
      pwm_q        <= '0;
      on_sh_q      <= 1'b0;
      mode_sh_q    <= '0;
      digits_sh_q  <= '0;
      flash_sh_q   <= '0;
      seg_q        <= '0;
      an_q         <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      fcnt_q       <= fcnt_d;
      blink_q      <= blink_d;
      pwm_q        <= pwm_d;
      on_sh_q      <= on_sh_d;
      mode_sh_q    <= mode_sh_d;
      digits_sh_q  <= digits_sh_d;
      flash_sh_q   <= flash_sh_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver with NUM_DIGITS=4, SCAN_DIV=4,
// BLINK_FRAMES=2, PWM_BITS=2. A cycle-count based reference derives the
// expected outputs for each clock edge and queues them; a negedge process
// pops and compares against the DUT.
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FRAME = ND * SD;

  logic        clk;
  logic        rst;
  logic        on;
  logic [2:0]  mode;
  logic [15:0] digits;
  logic [3:0]  flash_mask;
  logic [1:0]  bright;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;

  seg7_scan_driver #(
    .NUM_DIGITS  (ND),
    .SCAN_DIV    (SD),
    .BLINK_FRAMES(BF),
    .PWM_BITS    (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .on        (on),
    .mode      (mode),
    .digits    (digits),
    .flash_mask(flash_mask),
    .bright    (bright),
    .seg       (seg),
    .an        (an),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [6:0] ref_digit(input int v);
    case (v)
      0: return 7'h7E;   1: return 7'h30;   2: return 7'h6D;   3: return 7'h79;
      4: return 7'h33;   5: return 7'h5B;   6: return 7'h5F;   7: return 7'h70;
      8: return 7'h7F;   9: return 7'h7B;  10: return 7'h77;  11: return 7'h67;
      12: return 7'h01;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] ref_mode(input int m);
    case (m)
      0: return 7'h0E;  1: return 7'h7E;  2: return 7'h4E;
      3: return 7'h2F;  4: return 7'h4F;  5: return 7'h3D;
      default: return 7'h00;
    endcase
  endfunction

  // Expected {seg, an, frame_tick} per clock edge.
  logic [11:0] exp_q[$];

  // Reference state: cycles since reset release plus frame shadows.
  int          m_t = 0;
  logic        sh_on = 1'b0;
  logic [2:0]  sh_mode = '0;
  logic [15:0] sh_digits = '0;
  logic [3:0]  sh_flash = '0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_t       = 0;
        sh_on     = 1'b0;
        sh_mode   = '0;
        sh_digits = '0;
        sh_flash  = '0;
        exp_q.push_back(12'h000);
      end else begin
        int pre, idx, frame, blink, pwm, nibv;
        logic [6:0] e_seg;
        logic [3:0] e_an;
        logic       e_ft;
        logic       lit;
        pre   = m_t % SD;
        idx   = (m_t / SD) % ND;
        frame = m_t / FRAME;
        blink = (frame / BF) % 2;
        pwm   = m_t % 4;
        e_ft  = (pre == 0) && (idx == 0);
        e_seg = '0;
        e_an  = '0;
        if (pre != 0) begin
          e_an = 4'(1 << idx);
          nibv = int'((sh_digits >> (4 * idx)) & 16'hF);
          if (sh_on)
            e_seg = ref_digit(nibv);
          else if (idx == 0)
            e_seg = ref_mode(int'(sh_mode));
          lit = (bright == 2'd3) || (int'(bright) > pwm);
          if ((blink == 1 && sh_flash[idx]) || !lit)
            e_seg = '0;
        end
        exp_q.push_back({e_seg, e_an, e_ft});
        if (pre == SD - 1 && idx == ND - 1) begin
          sh_on     = on;
          sh_mode   = mode;
          sh_digits = digits;
          sh_flash  = flash_mask;
        end
        m_t++;
      end
    end
  end

  // Scoreboard consumer: compare each edge's outputs half a cycle later.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        logic [11:0] e;
        e = exp_q.pop_front();
        check_eq("seg", {9'd0, seg}, {9'd0, e[11:5]});
        check_eq("an", {12'd0, an}, {12'd0, e[4:1]});
        check_eq("frame_tick", {15'd0, frame_tick}, {15'd0, e[0]});
      end
    end
  end

  task automatic run_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bit found;
    rst        = 1'b1;
    on         = 1'b0;
    mode       = 3'd0;
    digits     = 16'h0000;
    flash_mask = 4'b0000;
    bright     = 2'd3;

    #2;
    check_eq("reset_seg", {9'd0, seg}, 16'd0);
    check_eq("reset_an", {12'd0, an}, 16'd0);
    check_eq("reset_ft", {15'd0, frame_tick}, 16'd0);

    run_cycles(3);
    rst = 1'b0;

    // First frame: mode 0 glyph from reset shadows; inputs for next frame.
    on     = 1'b1;
    digits = 16'h9A0C;
    run_cycles(3 * FRAME);

    // Mid-frame change of digits.
    run_cycles(5);
    digits = 16'h1234;
    run_cycles(2 * FRAME);

    // Flash digit 1.
    digits     = 16'h5678;
    flash_mask = 4'b0010;
    run_cycles(5 * FRAME);

    // Brightness.
    flash_mask = 4'b0000;
    bright     = 2'd1;
    run_cycles(2 * FRAME);
    bright = 2'd0;
    run_cycles(2 * FRAME);
    bright = 2'd2;
    run_cycles(2 * FRAME);
    bright = 2'd3;

    // Mode glyphs with flash on digit 0, then a sweep of all modes.
    on         = 1'b0;
    mode       = 3'd5;
    flash_mask = 4'b0001;
    run_cycles(5 * FRAME);
    flash_mask = 4'b0000;
    for (int m = 0; m < 8; m++) begin
      mode = 3'(m);
      run_cycles(FRAME);
    end

    // Asynchronous reset while digit 2 is displayed.
    on     = 1'b1;
    digits = 16'hBCDE;
    run_cycles(2 * FRAME);
    found = 1'b0;
    for (int k = 0; k < 2 * FRAME && !found; k++) begin
      @(negedge clk);
      if ((m_t % FRAME) >= 10 && (m_t % FRAME) <= 12) found = 1'b1;
    end
    check_eq("digit2_slot_found", {15'd0, found}, 16'd1);
    check_eq("an_before_rst", {12'd0, an}, 16'h0004);
    #1 rst = 1'b1;
    #1;
    check_eq("async_rst_seg", {9'd0, seg}, 16'd0);
    check_eq("async_rst_an", {12'd0, an}, 16'd0);
    check_eq("async_rst_ft", {15'd0, frame_tick}, 16'd0);
    run_cycles(2);
    rst    = 1'b0;
    digits = 16'h0987;
    run_cycles(3 * FRAME);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed seven-segment driver for the watch display. Decodes NUM_DIGITS BCD/hex nibbles, or a mode glyph when the watch is off, into a shared segment bus and a one-hot digit enable. Adds per-digit flash masking, PWM brightness control, and anti-ghost blanking between digit slots. Sits between the timekeeping/mode logic and the board display pins.

## Interface
- NUM_DIGITS, 4: number of multiplexed digits (≥1).
- SCAN_DIV, 2000: clock cycles per digit slot (≥2).
- BLINK_FRAMES, 50: frames per flash half-period (≥1).
- PWM_BITS, 3: brightness resolution.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- on  in  1  1 = show digits, 0 = show mode glyph.
- mode  in  3  mode glyph select.
- digits  in  4*NUM_DIGITS  nibble i at [4i+3:4i]; digit 0 is the rightmost digit.
- flash_mask  in  NUM_DIGITS  bit i = blink digit i.
- bright  in  PWM_BITS  duty: 0 = dark, all-ones = always lit.
- seg  out  7  {a,b,c,d,e,f,g}, active-high, registered.
- an  out  NUM_DIGITS  one-hot digit enable, active-high, registered.
- frame_tick  out  1  one-cycle pulse at the start of each frame, registered.

## Operation
- Counters: pre counts 0..SCAN_DIV-1. At pre = SCAN_DIV-1, pre wraps and idx advances 0..NUM_DIGITS-1, wrapping to 0. End-of-frame (EOF) = pre = SCAN_DIV-1 and idx = NUM_DIGITS-1.
- Shadow: on, mode, digits, and flash_mask are captured into shadow registers only on the EOF edge. No mid-frame tearing is possible. All decoding uses shadow values.
- Blink: fcnt counts frames 0..BLINK_FRAMES-1 and increments at EOF. When it wraps, blink phase toggles. Phase 0 = visible.
- PWM: pwm is a free-running PWM_BITS counter, incremented every cycle. lit = (bright == all-ones) or (pwm < bright).
- Digit glyphs (on=1), value → seg: 0 1111110, 1 0110000, 2 1101101, 3 1111001, 4 0110011, 5 1011011, 6 1011111, 7 1110000, 8 1111111, 9 1111011, 10 1110111, 11 1100111, 12 0000001 (dash), 13–15 blank.
- Mode glyphs (on=0): digit 0 shows the glyph below; all other digits are blank. Mode → seg: 0 0001110, 1 1111110, 2 1001110, 3 0101111, 4 1001111, 5 0111101, 6–7 blank.
- Anti-ghost: when pre = 0, an = 0 and seg = 0.
- Otherwise an = onehot(idx). seg = glyph, forced to 0 if (blink phase = 1 and shadow flash_mask[idx] = 1) or lit = 0. an stays asserted while seg is forced to 0.
- Flash applies in both on=1 and on=0 modes.

## Timing
- Reset values: seg = 0, an = 0, frame_tick = 0. pre, idx, fcnt, pwm, blink phase, and all shadow registers reset to 0. The shadow reset state means the first frame shows mode glyph 0 on digit 0.
- Output latency: outputs at edge t+1 are a function of counter/shadow state during cycle t, so an lags idx by 1 cycle.
- Each digit is enabled for SCAN_DIV-1 consecutive cycles, preceded by 1 blank cycle. Frame length = NUM_DIGITS*SCAN_DIV cycles.
- frame_tick = 1 on the cycle whose outputs derive from state pre = 0, idx = 0. This is the first blank cycle of a frame, one cycle after the shadow capture edge.
- Inputs changed mid-frame take effect on the first frame_tick after the next EOF.
- The blink phase toggles every BLINK_FRAMES frames. It takes effect from the first slot of the new frame.
- Reset asserted mid-frame: all outputs go to 0 immediately (asynchronous). Scanning restarts at digit 0 on the first edge after release.
- NUM_DIGITS = 1: idx stays 0, and every slot is an EOF slot.

## Test plan
Parameters for all scenarios: NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2, PWM_BITS=2.
- Reset release → an = 0000 and seg = 0 at release. First frame: an goes 0000 then 0001 for 3 cycles, seg = 0001110 (mode 0 glyph), then digits 1–3 blank. frame_tick pulses every 16 cycles.
- on=1, digits=16'h9A0C, bright=3 → from the second frame, seg sequence per slot: blank, then 0000001 on an=0001, 1111110 on 0010, 1110111 on 0100, 1111011 on 1000.
- Change digits mid-frame → old values persist until EOF. The new values appear on digit 0 on the cycle after the next frame_tick.
- flash_mask=0010 → digit 1 is lit for 2 frames and dark for 2 frames, with an=0010 still asserted. Other digits are unaffected.
- bright=1 → within each enabled digit slot, seg is nonzero only on cycles where pwm = 0. bright=0 → seg stays 0 with an still scanning.
- Assert rst during the digit 2 slot → seg, an, and frame_tick drop to 0 asynchronously. After release, the first enabled digit is digit 0.
